// File: rtl/debounce_filter.sv
// Debounce filter for a noisy asynchronous level input such as a switch or button.
// Raw_In passes through a two-flop synchronizer. A new level is accepted only after
// STABLE_COUNT consecutive enabled cycles at that level. Each accepted change raises
// a registered one-cycle rise or fall pulse together with the Clean_Out update.
//
// Supported range: 2 <= STABLE_COUNT <= 2**COUNT_WIDTH - 1.
//
// state       | meaning
// ------------+-------------------------------------------------------------
// STABLE_LOW  | Clean_Out = 0, waiting for an enabled synchronized high
// PEND_HIGH   | synchronized high seen, counting toward acceptance of a 1
// STABLE_HIGH | Clean_Out = 1, waiting for an enabled synchronized low
// PEND_LOW    | synchronized low seen, counting toward acceptance of a 0
module debounce_filter #(
  parameter int STABLE_COUNT = 4,
  parameter int COUNT_WIDTH  = 8
) (
  input  logic Clk_In,
  input  logic Reset_n_In,
  input  logic Enable_In,
  input  logic Raw_In,
  output logic Clean_Out,
  output logic Rise_Pulse_Out,
  output logic Fall_Pulse_Out,
  output logic Busy_Out
);

  typedef enum logic [1:0] {
    STABLE_LOW  = 2'b00,
    PEND_HIGH   = 2'b01,
    STABLE_HIGH = 2'b10,
    PEND_LOW    = 2'b11
  } state_t;

  // Value the counter holds in the cycle before a candidate level is accepted.
  localparam logic [COUNT_WIDTH-1:0] CNT_LAST = COUNT_WIDTH'(STABLE_COUNT - 1);
  localparam logic [COUNT_WIDTH-1:0] CNT_ONE  = COUNT_WIDTH'(1);

  logic                   sync_q1;
  logic                   sync_q2;
  state_t                 state_q;
  state_t                 state_d;
  logic [COUNT_WIDTH-1:0] count_q;
  logic [COUNT_WIDTH-1:0] count_d;
  logic                   clean_q;
  logic                   clean_d;
  logic                   rise_q;
  logic                   rise_d;
  logic                   fall_q;
  logic                   fall_d;

  // Two-flop synchronizer; sync_q2 is the only internal view of Raw_In.
  always_ff @(posedge Clk_In or negedge Reset_n_In) begin
    if (!Reset_n_In) begin
      sync_q1 <= 1'b0;
      sync_q2 <= 1'b0;
    end else begin
      sync_q1 <= Raw_In;
      sync_q2 <= sync_q1;
    end
  end

  // State, stability counter and registered outputs.
  always_ff @(posedge Clk_In or negedge Reset_n_In) begin
    if (!Reset_n_In) begin
      state_q <= STABLE_LOW;
      count_q <= '0;
      clean_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      clean_q <= clean_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  // Next-state logic. Losing the candidate level or dropping the enable both abandon
  // qualification without producing a pulse.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    clean_d = clean_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    unique case (state_q)
      STABLE_LOW: begin
        clean_d = 1'b0;
        count_d = '0;
        if (Enable_In && sync_q2) begin
          state_d = PEND_HIGH;
          count_d = CNT_ONE;
        end
      end
      PEND_HIGH: begin
        if (!Enable_In || !sync_q2) begin
          state_d = STABLE_LOW;
          count_d = '0;
        end else if (count_q == CNT_LAST) begin
          state_d = STABLE_HIGH;
          clean_d = 1'b1;
          rise_d  = 1'b1;
          count_d = '0;
        end else begin
          count_d = count_q + CNT_ONE;
        end
      end
      STABLE_HIGH: begin
        clean_d = 1'b1;
        count_d = '0;
        if (Enable_In && !sync_q2) begin
          state_d = PEND_LOW;
          count_d = CNT_ONE;
        end
      end
      PEND_LOW: begin
        if (!Enable_In || sync_q2) begin
          state_d = STABLE_HIGH;
          count_d = '0;
        end else if (count_q == CNT_LAST) begin
          state_d = STABLE_LOW;
          clean_d = 1'b0;
          fall_d  = 1'b1;
          count_d = '0;
        end else begin
          count_d = count_q + CNT_ONE;
        end
      end
      default: begin
        state_d = STABLE_LOW;
        count_d = '0;
        clean_d = 1'b0;
      end
    endcase
  end

  assign Clean_Out      = clean_q;
  assign Rise_Pulse_Out = rise_q;
  assign Fall_Pulse_Out = fall_q;
  assign Busy_Out       = (state_q == PEND_HIGH) || (state_q == PEND_LOW);

endmodule

// File: tb/tb_debounce_filter.sv
// Directed bench for debounce_filter. A run-length reference model is compared
// against the DUT on every falling clock edge. Literal expectations at specific
// edges pin the reference model itself.
module tb_debounce_filter;

  localparam int N = 4;

  logic clk;
  logic rst_n;
  logic en;
  logic raw;
  logic clean;
  logic rise;
  logic fall;
  logic busy;

  int vectors    = 0;
  int miscompares = 0;

  debounce_filter #(.STABLE_COUNT(N), .COUNT_WIDTH(8)) dut (
    .Clk_In        (clk),
    .Reset_n_In    (rst_n),
    .Enable_In     (en),
    .Raw_In        (raw),
    .Clean_Out     (clean),
    .Rise_Pulse_Out(rise),
    .Fall_Pulse_Out(fall),
    .Busy_Out      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model. The filter accepts the opposite level once the synchronized input
  // has differed from Clean_Out, with the enable high, for N consecutive edges.
  bit m_s1;
  bit m_s2;
  bit m_clean;
  bit m_rise;
  bit m_fall;
  int m_run;
  bit s_now;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_s1 = 0;
      m_s2 = 0;
      m_clean = 0;
      m_rise = 0;
      m_fall = 0;
      m_run = 0;
    end else begin
      s_now = m_s2;
      m_s2 = m_s1;
      m_s1 = raw;
      m_rise = 0;
      m_fall = 0;
      if (en && (s_now != m_clean)) m_run = m_run + 1;
      else m_run = 0;
      if (m_run == N) begin
        m_clean = !m_clean;
        m_rise = m_clean;
        m_fall = !m_clean;
        m_run = 0;
      end
    end
  end

  task automatic cmp(input string name, input logic act, input logic exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
    end
  endtask

  // Compare every cycle, half a period after the active edge.
  always @(negedge clk) begin
    if (rst_n) begin
      cmp("model_clean", clean, m_clean);
      cmp("model_rise", rise, m_rise);
      cmp("model_fall", fall, m_fall);
      cmp("model_busy", busy, m_run > 0);
      cmp("pulse_exclusive", rise & fall, 1'b0);
    end
  end

  // Advance one edge and settle 2 time units after it.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  int rise_cnt;
  int fall_cnt;

  task automatic tick_count();
    tick();
    if (rise) rise_cnt++;
    if (fall) fall_cnt++;
  endtask

  initial begin
    rst_n = 1'b0;
    en    = 1'b1;
    raw   = 1'b0;
    #1;
    cmp("reset_clean", clean, 1'b0);
    cmp("reset_rise", rise, 1'b0);
    cmp("reset_fall", fall, 1'b0);
    cmp("reset_busy", busy, 1'b0);
    #20;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) tick();

    // Clean rise: edge 1 is the first edge that samples raw = 1.
    raw = 1'b1;
    for (int e = 1; e <= 8; e++) begin
      tick();
      cmp($sformatf("rise_e%0d_rise", e), rise, e == 6);
      cmp($sformatf("rise_e%0d_clean", e), clean, e >= 6);
      cmp($sformatf("rise_e%0d_busy", e), busy, (e >= 3) && (e <= 5));
      if (e == 6) begin
        cmp("model_pin_rise", m_rise, 1'b1);
        cmp("model_pin_clean", m_clean, 1'b1);
      end
    end

    // Fall from Clean_Out = 1.
    raw = 1'b0;
    for (int e = 1; e <= 8; e++) begin
      tick();
      cmp($sformatf("fall_e%0d_fall", e), fall, e == 6);
      cmp($sformatf("fall_e%0d_clean", e), clean, e < 6);
      if (e == 6) cmp("model_pin_fall", m_fall, 1'b1);
    end

    // Glitch: three samples high, then low.
    rise_cnt = 0;
    fall_cnt = 0;
    raw = 1'b1;
    repeat (3) tick_count();
    raw = 1'b0;
    repeat (8) tick_count();
    cmp("glitch_rises", rise_cnt == 0, 1'b1);
    cmp("glitch_falls", fall_cnt == 0, 1'b0 == 1'b0 && fall_cnt == 0);
    cmp("glitch_clean", clean, 1'b0);
    cmp("glitch_busy", busy, 1'b0);

    // Bounce: 1,0,1,0 for one sample each, then held 1. The final 0->1 sample is edge 1.
    rise_cnt = 0;
    raw = 1'b1; tick();
    raw = 1'b0; tick();
    raw = 1'b1; tick();
    raw = 1'b0; tick();
    raw = 1'b1;
    for (int e = 1; e <= 8; e++) begin
      tick_count();
      cmp($sformatf("bounce_e%0d_rise", e), rise, e == 6);
    end
    cmp("bounce_one_rise", rise_cnt == 1, 1'b1);
    cmp("bounce_clean", clean, 1'b1);

    raw = 1'b0;
    repeat (8) tick();
    cmp("bounce_back_low", clean, 1'b0);

    // Enable: drop after edge 4 of a rise, restore after edge 5.
    raw = 1'b1;
    repeat (4) tick();
    cmp("enable_busy_before", busy, 1'b1);
    en = 1'b0;
    tick();
    cmp("enable_abort_busy", busy, 1'b0);
    cmp("enable_abort_rise", rise, 1'b0);
    cmp("enable_abort_clean", clean, 1'b0);
    en = 1'b1;
    for (int e = 6; e <= 10; e++) begin
      tick();
      cmp($sformatf("enable_e%0d_rise", e), rise, e == 9);
      cmp($sformatf("enable_e%0d_clean", e), clean, e >= 9);
    end

    // With the enable low, a held low input must not be accepted.
    en = 1'b0;
    raw = 1'b0;
    repeat (8) tick();
    cmp("disabled_hold_clean", clean, 1'b1);
    cmp("disabled_hold_busy", busy, 1'b0);
    en = 1'b1;
    repeat (8) tick();
    cmp("reenabled_fall_clean", clean, 1'b0);

    // Asynchronous reset mid-qualification, then requalify a held high input.
    raw = 1'b1;
    repeat (4) tick();
    cmp("reset_mid_busy_before", busy, 1'b1);
    #1 rst_n = 1'b0;
    #1;
    cmp("reset_mid_clean", clean, 1'b0);
    cmp("reset_mid_rise", rise, 1'b0);
    cmp("reset_mid_fall", fall, 1'b0);
    cmp("reset_mid_busy", busy, 1'b0);
    @(posedge clk);
    #3 rst_n = 1'b1;
    rise_cnt = 0;
    for (int e = 1; e <= 8; e++) begin
      tick_count();
      cmp($sformatf("post_reset_e%0d_rise", e), rise, e == 6);
    end
    cmp("post_reset_one_rise", rise_cnt == 1, 1'b1);
    cmp("post_reset_clean", clean, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
